// File: rtl/req_priority_encoder.sv
// Sticky request latch with one-at-a-time index serving over valid/ready.
// Define PRIO_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module req_priority_encoder #(
  parameter int N = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_req,
  input  logic             clr,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending,
  output logic             dup
);

  typedef enum logic [0:0] {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  function automatic logic [IDX_W-1:0] select_lowest(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = {IDX_W{1'b0}};
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && v[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

  state_t           state_r;
  logic [N-1:0]     pending_r;
  logic [IDX_W-1:0] out_idx_r;
  logic             out_valid_r;
  logic             dup_r;

  logic             hs_s;
  logic [N-1:0]     served_s;
  logic [N-1:0]     rem_s;
  logic [IDX_W-1:0] pick_idle_s;
  logic [IDX_W-1:0] pick_rem_s;

  // rem excludes same-cycle requests so a re-requested bit waits its turn.
  assign hs_s     = out_valid_r & out_ready;
  assign served_s = hs_s ? (ONE_HOT0 << out_idx_r) : {N{1'b0}};
  assign rem_s    = pending_r & ~served_s;

`ifdef PRIO_ROUND_ROBIN_EN
  function automatic logic [IDX_W-1:0] select_rr(input logic [N-1:0] v,
                                                 input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    int               j;
    idx   = {IDX_W{1'b0}};
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && v[j]) begin
        idx   = IDX_W'(j);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] next_ptr_s;

  // Back-to-back picks already search from the advanced pointer.
  assign next_ptr_s  = (out_idx_r == IDX_W'(N - 1)) ? {IDX_W{1'b0}} : out_idx_r + IDX_W'(1);
  assign pick_idle_s = select_rr(pending_r, rr_ptr_r);
  assign pick_rem_s  = select_rr(rem_s, next_ptr_s);

  // Rotation pointer advances past each accepted index; a flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= {IDX_W{1'b0}};
    end else if (!clr && hs_s) begin
      rr_ptr_r <= next_ptr_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  assign pick_idle_s = select_lowest(pending_r);
  assign pick_rem_s  = select_lowest(rem_s);
`endif

  // Pending latch, duplicate detection and the IDLE/PRESENT offer state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pending_r   <= {N{1'b0}};
      out_idx_r   <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      dup_r       <= 1'b0;
    end else if (clr) begin
      state_r     <= IDLE;
      pending_r   <= {N{1'b0}};
      out_valid_r <= 1'b0;
      dup_r       <= 1'b0;
    end else begin
      pending_r <= rem_s | in_req;
      dup_r     <= |(in_req & rem_s);
      case (state_r)
        IDLE: begin
          if (pending_r != {N{1'b0}}) begin
            out_idx_r   <= pick_idle_s;
            out_valid_r <= 1'b1;
            state_r     <= PRESENT;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        PRESENT: begin
          if (hs_s) begin
            if (rem_s != {N{1'b0}}) begin
              out_idx_r <= pick_rem_s;
            end else begin
              out_valid_r <= 1'b0;
              state_r     <= IDLE;
            end
          end else begin
            out_idx_r <= out_idx_r;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign out_idx   = out_idx_r;
  assign out_valid = out_valid_r;
  assign pending   = pending_r;
  assign dup       = dup_r;

endmodule

// File: tb/tb_req_priority_encoder.sv
// Randomised and directed bench for req_priority_encoder, checked against a behavioural model.
module tb_req_priority_encoder;

  localparam int N = 8;
`ifdef PRIO_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_req;
  logic       clr;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       dup;

  int n_tests = 0;
  int n_fail  = 0;

  req_priority_encoder #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .clr(clr),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .pending(pending), .dup(dup)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pend;
    logic       valid;
    int         idx;
    logic       dup;
    int         ptr;
  } model_t;

  model_t m;

  // First set bit of v searching upward from start, wrapping; -1 if none.
  function automatic int pick(input logic [7:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic model_t model_next(input model_t s, input logic [7:0] req,
                                        input logic rdy, input logic flush);
    model_t     n;
    logic [7:0] served;
    logic [7:0] rem;
    int         nptr;
    n      = s;
    served = (s.valid && rdy) ? 8'(1 << s.idx) : 8'h00;
    rem    = s.pend & ~served;
    if (flush) begin
      n.pend  = 8'h00;
      n.valid = 1'b0;
      n.dup   = 1'b0;
    end else begin
      n.pend = rem | req;
      n.dup  = (req & rem) != 8'h00;
      if (!s.valid) begin
        if (s.pend != 8'h00) begin
          n.idx   = pick(s.pend, RR ? s.ptr : 0);
          n.valid = 1'b1;
        end
      end else if (rdy) begin
        nptr  = (s.idx + 1) % N;
        n.ptr = RR ? nptr : 0;
        if (rem != 8'h00) n.idx = pick(rem, RR ? nptr : 0);
        else n.valid = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m, in_req, out_ready, clr);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid", int'(out_valid), int'(m.valid));
      if (m.valid) chk("model_idx", int'(out_idx), m.idx);
      chk("model_pending", int'(pending), int'(m.pend));
      chk("model_dup", int'(dup), int'(m.dup));
    end
  end

  task automatic nclk();
    @(negedge clk);
  endtask

  int grants3;

  initial begin
    rst_n = 1'b0; in_req = 8'h00; clr = 1'b0; out_ready = 1'b0;
    repeat (3) nclk();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_dup", int'(dup), 0);
    rst_n = 1'b1;
    nclk();

    // 1: single request
    in_req = 8'h01; out_ready = 1'b1;
    nclk(); in_req = 8'h00;
    chk("t1_pend", int'(pending), 8'h01);
    chk("t1_valid0", int'(out_valid), 0);
    nclk();
    chk("t1_valid1", int'(out_valid), 1);
    chk("t1_idx", int'(out_idx), 0);
    nclk();
    chk("t1_done", int'(out_valid), 0);
    chk("t1_pend0", int'(pending), 0);

    // 2: 0x94 -> 2,4,7
    in_req = 8'h94;
    nclk(); in_req = 8'h00;
    nclk(); chk("t2_idx2", int'(out_idx), 2); chk("t2_v2", int'(out_valid), 1);
    nclk(); chk("t2_idx4", int'(out_idx), 4); chk("t2_pend", int'(pending), 8'h90);
    nclk(); chk("t2_idx7", int'(out_idx), 7);
    nclk(); chk("t2_done", int'(out_valid), 0);

    // 3: stall with 0x81 pending, 0x02 arrives mid-stall
    out_ready = 1'b0; in_req = 8'h81;
    nclk(); in_req = 8'h00;
    nclk(); chk("t3_idx0", int'(out_idx), 0);
    for (int i = 0; i < 5; i++) begin
      in_req = (i == 2) ? 8'h02 : 8'h00;
      nclk();
      chk("t3_hold", int'(out_idx), 0);
      chk("t3_hold_v", int'(out_valid), 1);
    end
    in_req = 8'h00; out_ready = 1'b1;
    nclk(); chk("t3_idx1", int'(out_idx), 1);
    nclk(); chk("t3_idx7", int'(out_idx), 7);
    nclk(); chk("t3_done", int'(out_valid), 0);

    // 4: duplicate on bit 3
    out_ready = 1'b0; in_req = 8'h08;
    nclk(); chk("t4_nodup", int'(dup), 0);
    in_req = 8'h08;
    nclk(); chk("t4_dup", int'(dup), 1); in_req = 8'h00;
    chk("t4_idx3", int'(out_idx), 3);
    nclk(); chk("t4_dup_end", int'(dup), 0);
    out_ready = 1'b1;
    grants3 = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_idx == 3'd3) grants3++;
      nclk();
    end
    chk("t4_one_grant", grants3, 1);

    // 5: clr with same-cycle request while presenting
    in_req = 8'h01;
    nclk(); in_req = 8'h00;
    nclk(); chk("t5_v", int'(out_valid), 1);
    clr = 1'b1; in_req = 8'h10;
    nclk(); clr = 1'b0; in_req = 8'h00;
    chk("t5_pend0", int'(pending), 0);
    chk("t5_v0", int'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      nclk();
      chk("t5_no4", int'(out_valid), 0);
    end

    // 6: re-pulse bits 0,1 on every handshake, then async reset mid-stream
    in_req = 8'h03;
    for (int i = 0; i < 10; i++) begin
      nclk();
      in_req = (out_valid && out_ready) ? 8'h03 : 8'h00;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_idx", int'(out_idx), 0);
    chk("t6_rst_pend", int'(pending), 0);
    chk("t6_rst_dup", int'(dup), 0);
    in_req = 8'h00;
    nclk(); rst_n = 1'b1;
    nclk();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_req    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      nclk();
    end
    in_req = 8'h00; clr = 1'b0; out_ready = 1'b1;
    repeat (12) nclk();
    chk("drain_valid", int'(out_valid), 0);
    chk("drain_pend", int'(pending), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
